// File: rtl/prv32_id_ex_stage.sv
// prv32 ID/EX pipeline register: single-entry valid/ready buffer feeding the ALU.
// Optional MEM/WB operand bypass and hold-time snoop are enabled by defining PRV32_FWD_EN.
module prv32_id_ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            id_valid,
    output logic            id_ready,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic [3:0]      id_alufn,
    input  logic            id_alusrc,
    input  logic            id_asel_pc,
    input  logic            id_regwrite,

    input  logic            flush,

    input  logic            mem_we,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_data,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,

    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [4:0]      alu_shamt,
    output logic [3:0]      alu_alufn,
    output logic [XLEN-1:0] ex_pc,
    output logic [4:0]      ex_rd,
    output logic            ex_regwrite
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] rs1_val;
        logic [XLEN-1:0] rs2_val;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic [3:0]      alufn;
        logic            alusrc;
        logic            asel_pc;
        logic            regwrite;
    } entry_t;

    entry_t          entry_q;
    entry_t          entry_d;
    logic            valid_q;
    logic            valid_d;
    logic            capture;
    logic            hold;
    logic            drain;
    logic [XLEN-1:0] cap_rs1_val;
    logic [XLEN-1:0] cap_rs2_val;
    logic [XLEN-1:0] snoop_rs1_val;
    logic [XLEN-1:0] snoop_rs2_val;

    assign id_ready = !valid_q || ex_ready;
    assign capture  = id_valid && id_ready && !flush;
    assign hold     = valid_q && !ex_ready;
    assign drain    = valid_q && ex_ready;

`ifdef PRV32_FWD_EN
    // MEM is the younger producer, so it wins over WB; x0 always reads as its register-file value.
    function automatic logic [XLEN-1:0] bypass(
        input logic [4:0]      rs,
        input logic [XLEN-1:0] cur,
        input logic            m_we,
        input logic [4:0]      m_rd,
        input logic [XLEN-1:0] m_data,
        input logic            w_we,
        input logic [4:0]      w_rd,
        input logic [XLEN-1:0] w_data
    );
        logic [XLEN-1:0] res;
        res = cur;
        if (rs != 5'd0) begin
            if (m_we && (m_rd == rs))
                res = m_data;
            else if (w_we && (w_rd == rs))
                res = w_data;
        end
        return res;
    endfunction

    assign cap_rs1_val   = bypass(id_rs1, id_rs1_data, mem_we, mem_rd, mem_data,
                                  wb_we, wb_rd, wb_data);
    assign cap_rs2_val   = bypass(id_rs2, id_rs2_data, mem_we, mem_rd, mem_data,
                                  wb_we, wb_rd, wb_data);
    assign snoop_rs1_val = bypass(entry_q.rs1, entry_q.rs1_val, mem_we, mem_rd, mem_data,
                                  wb_we, wb_rd, wb_data);
    assign snoop_rs2_val = bypass(entry_q.rs2, entry_q.rs2_val, mem_we, mem_rd, mem_data,
                                  wb_we, wb_rd, wb_data);
`else
    // Without forwarding decode stalls on hazards, so the bypass ports and stored indices go unused.
    assign cap_rs1_val   = id_rs1_data;
    assign cap_rs2_val   = id_rs2_data;
    assign snoop_rs1_val = entry_q.rs1_val;
    assign snoop_rs2_val = entry_q.rs2_val;

    logic unused_fwd;
    assign unused_fwd = ^{mem_we, mem_rd, mem_data, wb_we, wb_rd, wb_data,
                          entry_q.rs1, entry_q.rs2};
`endif

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        entry_d = entry_q;
        if (capture) begin
            entry_d.pc       = id_pc;
            entry_d.rs1      = id_rs1;
            entry_d.rs2      = id_rs2;
            entry_d.rs1_val  = cap_rs1_val;
            entry_d.rs2_val  = cap_rs2_val;
            entry_d.imm      = id_imm;
            entry_d.rd       = id_rd;
            entry_d.alufn    = id_alufn;
            entry_d.alusrc   = id_alusrc;
            entry_d.asel_pc  = id_asel_pc;
            entry_d.regwrite = id_regwrite;
        end else if (hold) begin
            entry_d.rs1_val  = snoop_rs1_val;
            entry_d.rs2_val  = snoop_rs2_val;
        end
    end

    always_comb begin
        valid_d = valid_q;
        if (flush)
            valid_d = 1'b0;
        else if (capture)
            valid_d = 1'b1;
        else if (drain)
            valid_d = 1'b0;
    end

    // Datapath fields are reset too, because their zero values are visible on the outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_q <= '0;
            valid_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            entry_q <= entry_d;
            valid_q <= valid_d;
        end
    end

    assign ex_valid    = valid_q;
    assign alu_a       = entry_q.asel_pc ? entry_q.pc  : entry_q.rs1_val;
    assign alu_b       = entry_q.alusrc  ? entry_q.imm : entry_q.rs2_val;
    assign alu_shamt   = alu_b[4:0];
    assign alu_alufn   = entry_q.alufn;
    assign ex_pc       = entry_q.pc;
    assign ex_rd       = entry_q.rd;
    assign ex_regwrite = valid_q && entry_q.regwrite;

endmodule

// File: tb/tb_prv32_id_ex_stage.sv
// Directed self-checking bench for prv32_id_ex_stage; expectations follow PRV32_FWD_EN.
module tb_prv32_id_ex_stage;

`ifdef PRV32_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [3:0]  id_alufn;
    logic        id_alusrc, id_asel_pc, id_regwrite;
    logic        flush;
    logic        mem_we, wb_we;
    logic [4:0]  mem_rd, wb_rd;
    logic [31:0] mem_data, wb_data;
    logic        ex_valid, ex_ready;
    logic [31:0] alu_a, alu_b, ex_pc;
    logic [4:0]  alu_shamt, ex_rd;
    logic [3:0]  alu_alufn;
    logic        ex_regwrite;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    prv32_id_ex_stage dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alufn(id_alufn),
        .id_alusrc(id_alusrc), .id_asel_pc(id_asel_pc), .id_regwrite(id_regwrite),
        .flush(flush),
        .mem_we(mem_we), .mem_rd(mem_rd), .mem_data(mem_data),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt), .alu_alufn(alu_alufn),
        .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [31:0] pc, input logic [31:0] d1, input logic [31:0] d2,
                             input logic [31:0] imm, input logic [4:0] r1, input logic [4:0] r2,
                             input logic [4:0] rd, input logic [3:0] fn, input logic src,
                             input logic asel, input logic rw);
        id_valid = 1'b1; id_pc = pc; id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
        id_rs1 = r1; id_rs2 = r2; id_rd = rd; id_alufn = fn;
        id_alusrc = src; id_asel_pc = asel; id_regwrite = rw;
    endtask

    task automatic clear_bypass();
        mem_we = 1'b0; mem_rd = 5'd0; mem_data = '0;
        wb_we  = 1'b0; wb_rd  = 5'd0; wb_data  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; ex_ready = 1'b1;
        set_instr('0, '0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        id_valid = 1'b0;
        clear_bypass();
        #12;
        if (ex_valid !== 1'b0) begin $display("FAIL reset_ex_valid: got %b expected 0", ex_valid); errors++; end
        checks++;
        if (id_ready !== 1'b1) begin $display("FAIL reset_id_ready: got %b expected 1", id_ready); errors++; end
        checks++;
        if ({alu_a, alu_b, alu_shamt, alu_alufn, ex_pc, ex_rd, ex_regwrite} !== '0) begin
            $display("FAIL reset_outputs: got a=%h b=%h sh=%h fn=%h pc=%h rd=%h rw=%b expected all 0",
                     alu_a, alu_b, alu_shamt, alu_alufn, ex_pc, ex_rd, ex_regwrite);
            errors++;
        end
        checks++;
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        ex_ready = 1'b1;
        set_instr(32'h10, 32'd50, 32'd70, 32'h0, 5'd5, 5'd7, 5'd8, 4'd0, 1'b0, 1'b0, 1'b1);
        tick();
        if (ex_valid !== 1'b1) begin $display("FAIL b2b_valid0: got %b expected 1", ex_valid); errors++; end
        checks++;
        if (alu_alufn !== 4'd0) begin $display("FAIL b2b_alufn0: got %h expected 0", alu_alufn); errors++; end
        checks++;
        if (alu_a !== 32'd50 || alu_b !== 32'd70) begin
            $display("FAIL b2b_operands: got a=%h b=%h expected a=32 b=46", alu_a, alu_b); errors++;
        end
        checks++;
        if (ex_regwrite !== 1'b1 || ex_rd !== 5'd8) begin
            $display("FAIL b2b_rd: got rw=%b rd=%0d expected rw=1 rd=8", ex_regwrite, ex_rd); errors++;
        end
        checks++;
        set_instr(32'h14, 32'd9, 32'd4, 32'h0, 5'd5, 5'd7, 5'd9, 4'd1, 1'b0, 1'b0, 1'b1);
        tick();
        if (ex_valid !== 1'b1) begin $display("FAIL b2b_valid1: got %b expected 1", ex_valid); errors++; end
        checks++;
        if (alu_alufn !== 4'd1 || ex_pc !== 32'h14) begin
            $display("FAIL b2b_alufn1: got fn=%h pc=%h expected fn=1 pc=14", alu_alufn, ex_pc); errors++;
        end
        checks++;
        id_valid = 1'b0;
        tick();
        if (ex_valid !== 1'b0 || ex_regwrite !== 1'b0) begin
            $display("FAIL b2b_drain: got valid=%b rw=%b expected 0 0", ex_valid, ex_regwrite); errors++;
        end
        checks++;
    endtask

    task automatic test_bypass();
        ex_ready = 1'b1;
        set_instr(32'h20, 32'h1111, 32'h3333, 32'h0, 5'd3, 5'd6, 5'd1, 4'd0, 1'b0, 1'b0, 1'b1);
        mem_we = 1'b1; mem_rd = 5'd3; mem_data = 32'hAAAA;
        wb_we  = 1'b1; wb_rd  = 5'd3; wb_data  = 32'h5555;
        tick();
        if (alu_a !== (FWD ? 32'hAAAA : 32'h1111)) begin
            $display("FAIL bypass_mem_priority: got %h expected %h", alu_a, FWD ? 32'hAAAA : 32'h1111); errors++;
        end
        checks++;
        if (alu_b !== 32'h3333) begin $display("FAIL bypass_no_match: got %h expected 3333", alu_b); errors++; end
        checks++;
        mem_we = 1'b0; wb_rd = 5'd6; wb_data = 32'h6666;
        tick();
        if (alu_b !== (FWD ? 32'h6666 : 32'h3333) || alu_a !== 32'h1111) begin
            $display("FAIL bypass_wb_rs2: got a=%h b=%h expected a=1111 b=%h", alu_a, alu_b,
                     FWD ? 32'h6666 : 32'h3333);
            errors++;
        end
        checks++;
        set_instr(32'h24, 32'h2222, 32'h0, 32'h0, 5'd0, 5'd0, 5'd2, 4'd0, 1'b0, 1'b0, 1'b1);
        mem_we = 1'b1; mem_rd = 5'd0; mem_data = 32'hAAAA;
        wb_we  = 1'b1; wb_rd  = 5'd0; wb_data  = 32'h5555;
        tick();
        if (alu_a !== 32'h2222) begin $display("FAIL bypass_x0: got %h expected 2222", alu_a); errors++; end
        checks++;
        id_valid = 1'b0;
        clear_bypass();
        tick();
    endtask

    task automatic test_hold_snoop();
        ex_ready = 1'b0;
        set_instr(32'h40, 32'h11, 32'h0F0F, 32'h0, 5'd1, 5'd4, 5'd9, 4'd5, 1'b0, 1'b0, 1'b1);
        tick();
        id_valid = 1'b0;
        if (id_ready !== 1'b0 || alu_b !== 32'h0F0F) begin
            $display("FAIL hold_capture: got rdy=%b b=%h expected rdy=0 b=0f0f", id_ready, alu_b); errors++;
        end
        checks++;
        wb_we = 1'b1; wb_rd = 5'd4; wb_data = 32'h1234;
        if (id_ready !== 1'b0) begin $display("FAIL hold_ready_pre: got %b expected 0", id_ready); errors++; end
        checks++;
        tick();
        wb_we = 1'b0;
        if (alu_b !== (FWD ? 32'h1234 : 32'h0F0F) || alu_shamt !== (FWD ? 5'h14 : 5'h0F)) begin
            $display("FAIL hold_snoop: got b=%h sh=%h expected b=%h sh=%h", alu_b, alu_shamt,
                     FWD ? 32'h1234 : 32'h0F0F, FWD ? 5'h14 : 5'h0F);
            errors++;
        end
        checks++;
        if (ex_pc !== 32'h40 || ex_rd !== 5'd9 || alu_alufn !== 4'd5 || alu_a !== 32'h11 || id_ready !== 1'b0) begin
            $display("FAIL hold_stable: got pc=%h rd=%0d fn=%h a=%h rdy=%b expected pc=40 rd=9 fn=5 a=11 rdy=0",
                     ex_pc, ex_rd, alu_alufn, alu_a, id_ready);
            errors++;
        end
        checks++;
        #2 wb_we = 1'b1; wb_data = 32'h9999;
        #2 wb_we = 1'b0;
        tick();
        if (alu_b !== (FWD ? 32'h1234 : 32'h0F0F)) begin
            $display("FAIL hold_between_edges: got %h expected %h", alu_b, FWD ? 32'h1234 : 32'h0F0F); errors++;
        end
        checks++;
    endtask

    task automatic test_flush();
        set_instr(32'h80, 32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 5'd3, 4'd2, 1'b0, 1'b0, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0; id_valid = 1'b0;
        if (ex_valid !== 1'b0 || ex_regwrite !== 1'b0) begin
            $display("FAIL flush_hold: got valid=%b rw=%b expected 0 0", ex_valid, ex_regwrite); errors++;
        end
        checks++;
        if (ex_pc !== 32'h40) begin $display("FAIL flush_dropped: got pc=%h expected 40", ex_pc); errors++; end
        checks++;
        ex_ready = 1'b1;
    endtask

    task automatic test_pc_imm();
        ex_ready = 1'b1;
        set_instr(32'h100, 32'h7777, 32'h8888, 32'h2000, 5'd2, 5'd3, 5'd10, 4'd0, 1'b1, 1'b1, 1'b1);
        tick();
        id_valid = 1'b0;
        if (alu_a !== 32'h100 || alu_b !== 32'h2000 || alu_shamt !== 5'h00) begin
            $display("FAIL auipc_select: got a=%h b=%h sh=%h expected a=100 b=2000 sh=0", alu_a, alu_b, alu_shamt);
            errors++;
        end
        checks++;
    endtask

    task automatic test_reset_midstream();
        ex_ready = 1'b0;
        set_instr(32'h200, 32'hDEAD, 32'hBEEF, 32'h0, 5'd7, 5'd8, 5'd11, 4'd3, 1'b0, 1'b0, 1'b1);
        tick();
        id_valid = 1'b0;
        if (ex_valid !== 1'b1) begin $display("FAIL midrst_pre: got %b expected 1", ex_valid); errors++; end
        checks++;
        #2 rst = 1'b1;
        #1;
        if (ex_valid !== 1'b0 || id_ready !== 1'b1 || ex_regwrite !== 1'b0) begin
            $display("FAIL midrst_ctrl: got valid=%b rdy=%b rw=%b expected 0 1 0", ex_valid, id_ready, ex_regwrite);
            errors++;
        end
        checks++;
        if ({alu_a, alu_b, alu_alufn, ex_pc, ex_rd} !== '0) begin
            $display("FAIL midrst_data: got a=%h b=%h fn=%h pc=%h rd=%h expected all 0",
                     alu_a, alu_b, alu_alufn, ex_pc, ex_rd);
            errors++;
        end
        checks++;
        @(negedge clk);
        rst = 1'b0;
        ex_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_bypass();
        test_hold_snoop();
        test_flush();
        test_pc_imm();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
